riscv_mem_arbiter: RTL
======================

Name: riscv_mem_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch requester and its data (load/store) requester.
- Allows a single-cycle or multi-cycle riscv datapath to run against one unified memory.
- Serialises accesses with a req/ack handshake, gives data access priority, and prevents fetch starvation.
- Drives a stall output that freezes the datapath while either requester waits.

Parameters:
- XLEN, 32: address and data width.
- MEM_LATENCY, 2: cycles from mem_en asserted until mem_rdata is valid. Legal range is 1..7.
- STARVE_LIMIT, 3: maximum consecutive data grants while i_req is pending. The next grant must then go to fetch. Legal range is 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  XLEN  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  XLEN  fetched word; equals mem_rdata when i_ack=1, otherwise 0.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=store, 0=load; stable while d_req is high.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  XLEN  load data; equals mem_rdata when d_ack=1, otherwise 0.
- mem_en  out  1  memory access strobe; registered; high for exactly one cycle per access.
- mem_we  out  1  memory write enable; registered; valid with mem_en.
- mem_addr  out  XLEN  registered access address.
- mem_wdata  out  XLEN  registered write data.
- mem_rdata  in  XLEN  memory read data; valid MEM_LATENCY cycles after the mem_en cycle.
- stall  out  1  (i_req & ~i_ack) | (d_req & ~d_ack); combinational.

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (rst=1 at clock edge):
  - state=IDLE; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - i_ack=0, d_ack=0; latency counter=0, starve counter=0; owner=none.
  - Reset overrides everything, including mid-transaction. An outstanding access is abandoned with no ack, and any late mem_rdata is ignored.
- IDLE, no request: stay in IDLE; mem_en=0.
- IDLE, request present: the grant is decided this cycle.
  - Grant data if d_req=1, unless i_req=1 and starve counter==STARVE_LIMIT. Otherwise grant fetch if i_req=1.
  - At the edge: register mem_addr / mem_we / mem_wdata from the winner. For fetch, mem_we=0 and mem_wdata=0. Set mem_en=1, record owner, go to ISSUE.
- Starve counter:
  - On a data grant with i_req=1: increment, saturating at STARVE_LIMIT.
  - On a data grant with i_req=0: clear.
  - On a fetch grant: clear.
- ISSUE: lasts one cycle, with mem_en=1.
  - Next edge: mem_en=0, latency counter=1, go to WAIT.
  - If MEM_LATENCY==1, the ack is given in the cycle after ISSUE.
- WAIT:
  - While latency counter < MEM_LATENCY: increment each cycle.
  - In the cycle where counter==MEM_LATENCY, the owner's ack=1 (combinational from state/counter/owner). The owner's rdata = mem_rdata; the other requester's rdata=0.
  - Next edge: go to IDLE, owner=none.
  - Stores also ack at MEM_LATENCY cycles; d_rdata is don't-care for stores but driven from mem_rdata.
- Timing: a request first seen in IDLE at cycle T gets mem_en at T+1 and ack at T+1+MEM_LATENCY. The earliest next issue is mem_en at T+3+MEM_LATENCY, because IDLE re-arbitrates at T+2+MEM_LATENCY.
- One outstanding access at a time. Requests arriving in ISSUE/WAIT are held by the requester and considered in the next IDLE.
- The requester may drop req only after its ack cycle. Dropping req early is illegal. The arbiter does not check for it and still completes the access with an ack.
- stall is asserted in every cycle a requester is waiting, and is low in the ack cycle if no other request is pending.
- Addresses and data are passed unmodified. There is no alignment checking.

Test Plan:
- Fetch only (MEM_LATENCY=2):
  - Stimulus: i_req=1, i_addr=0x00400000 at cycle 0; memory returns 0x00500093.
  - Required: mem_en=1, mem_we=0, mem_addr=0x00400000 at cycle 1; i_ack=1 and i_rdata=0x00500093 at cycle 3; stall=1 in cycles 0-2 and 0 at cycle 3.
- Simultaneous requests:
  - Stimulus: i_req and d_req (load, d_addr=0x10010000) both high at cycle 0.
  - Required: data issued at cycle 1, d_ack at cycle 3; fetch issued at cycle 5, i_ack at cycle 7; i_ack stays 0 until then.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x10010004, d_wdata=0xDEADBEEF.
  - Required: in the issue cycle, mem_en=1, mem_we=1, mem_addr=0x10010004, mem_wdata=0xDEADBEEF; d_ack exactly MEM_LATENCY cycles later, one cycle wide.
- Starvation guard (STARVE_LIMIT=3):
  - Stimulus: d_req re-asserted back-to-back and i_req held high continuously.
  - Required: exactly 3 data grants, then a fetch grant even though d_req=1; the starve counter then clears.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle during WAIT of a load.
  - Required: no d_ack is ever produced for that load; next cycle state=IDLE, mem_en=0, all outputs 0; a fresh request afterwards completes normally.
- MEM_LATENCY=1 sweep:
  - Stimulus: back-to-back fetches.
  - Required: ack one cycle after each mem_en; mem_en pulses spaced 3 cycles apart.

Source files
------------

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared
// single-port memory. The arbiter connects through the slave modport, and the
// core/memory side connects through the master modport.
interface riscv_mem_arbiter_if #(
  parameter int XLEN = 32
);
  // Fetch requester
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_ack;
  logic [XLEN-1:0] i_rdata;
  // Data (load/store) requester
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;
  // Shared memory port
  logic            mem_en;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  // Datapath freeze
  logic            stall;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data has priority. However, after STARVE_LIMIT consecutive data grants with a
// fetch pending, the next grant goes to fetch. One access is in flight at a time:
// IDLE arbitrates, ISSUE pulses mem_en, and WAIT counts MEM_LATENCY cycles and
// acks the owner.
module riscv_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int MEM_LATENCY  = 2,   // 1..7
  parameter int STARVE_LIMIT = 3    // 1..15
) (
  input logic                clk,
  input logic                rst,
  riscv_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  state_t          state_r;
  state_t          state_nxt_s;
  owner_t          owner_r;
  logic [2:0]      lat_r;
  logic [3:0]      starve_r;
  logic            mem_en_r;
  logic            mem_we_r;
  logic [XLEN-1:0] mem_addr_r;
  logic [XLEN-1:0] mem_wdata_r;

  logic            grant_d_s;
  logic            grant_i_s;
  logic            ack_s;
  logic            lat_done_s;
  logic            starve_full_s;
  logic            i_ack_s;
  logic            d_ack_s;

  assign lat_done_s    = (lat_r == 3'(MEM_LATENCY));
  assign starve_full_s = (starve_r == 4'(STARVE_LIMIT));

  // Arbitration, next-state selection and ack decode
  always_comb begin
    state_nxt_s = state_r;
    grant_d_s   = 1'b0;
    grant_i_s   = 1'b0;
    ack_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.d_req && !(bus.i_req && starve_full_s)) begin
          grant_d_s = 1'b1;
        end else if (bus.i_req) begin
          grant_i_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
        end
        if (grant_d_s || grant_i_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_done_s) begin
          ack_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, ownership, counters and registered memory strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWN_NONE;
      lat_r       <= 3'd0;
      starve_r    <= 4'd0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {XLEN{1'b0}};
      mem_wdata_r <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (grant_d_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= bus.d_we;
            mem_addr_r  <= bus.d_addr;
            mem_wdata_r <= bus.d_wdata;
            owner_r     <= OWN_DATA;
            // Count data wins only while fetch is actually waiting.
            if (bus.i_req) begin
              starve_r <= starve_full_s ? starve_r : (starve_r + 4'd1);
            end else begin
              starve_r <= 4'd0;
            end
          end else if (grant_i_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= bus.i_addr;
            mem_wdata_r <= {XLEN{1'b0}};
            owner_r     <= OWN_FETCH;
            starve_r    <= 4'd0;
          end else begin
            mem_en_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // Write enable is only meaningful alongside mem_en. Drop both together.
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          lat_r    <= 3'd1;
        end
        ST_WAIT: begin
          if (lat_done_s) begin
            owner_r <= OWN_NONE;
          end else begin
            lat_r <= lat_r + 3'd1;
          end
        end
        default: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          owner_r  <= OWN_NONE;
        end
      endcase
    end
  end

  assign i_ack_s = ack_s && (owner_r == OWN_FETCH);
  assign d_ack_s = ack_s && (owner_r == OWN_DATA);

  assign bus.i_ack     = i_ack_s;
  assign bus.d_ack     = d_ack_s;
  assign bus.i_rdata   = i_ack_s ? bus.mem_rdata : {XLEN{1'b0}};
  assign bus.d_rdata   = d_ack_s ? bus.mem_rdata : {XLEN{1'b0}};
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.stall     = (bus.i_req && !i_ack_s) || (bus.d_req && !d_ack_s);

endmodule
